// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O peripheral for the single-cycle RISC-V system.
// Provides readable LED/HEX registers, debounced push-buttons with sticky
// press-event capture, a free-running cycle counter and an optional interrupt.
//
// Optional feature macro: MMIO_IO_IRQ_EN
//   defined   -> IRQ_MASK register at 0x14, irq = registered |(key_edge & irq_mask)
//   undefined -> irq tied low, 0x14 reads 0 and ignores writes, no mask flops
//
// Register map (word index = addr[4:2]):
//   0x00 LEDS (RW)  0x04 HEX (RW)  0x08 KEY_LEVEL (RO)  0x0C KEY_EDGE (W1C)
//   0x10 TICK (RW)  0x14 IRQ_MASK (RW, optional)  0x18..0x1C unmapped
module mmio_io_ctrl #(
  parameter int LED_W        = 10,
  parameter int NUM_HEX      = 6,
  parameter int KEY_W        = 4,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [KEY_W-1:0]     key_n,
  output logic [LED_W-1:0]     leds,
  output logic [4*NUM_HEX-1:0] hex_digits,
  output logic                 irq
);

  localparam int HEX_W = 4 * NUM_HEX;
  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    REG_LEDS      = 3'd0,
    REG_HEX       = 3'd1,
    REG_KEY_LEVEL = 3'd2,
    REG_KEY_EDGE  = 3'd3,
    REG_TICK      = 3'd4,
    REG_IRQ_MASK  = 3'd5,
    REG_RSVD6     = 3'd6,
    REG_RSVD7     = 3'd7
  } reg_e;

  // Byte-lane bits are not decoded; keep them visibly consumed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  reg_e reg_idx;
  logic wr_en;
  assign reg_idx = reg_e'(addr[4:2]);
  assign wr_en   = sel & we;

  // State
  logic [LED_W-1:0] leds_q, leds_d;
  logic [HEX_W-1:0] hex_q, hex_d;
  logic [31:0]      tick_q, tick_d;
  logic [KEY_W-1:0] sync1_q, sync1_d;
  logic [KEY_W-1:0] sync2_q, sync2_d;
  logic [KEY_W-1:0] key_level_q, key_level_d;
  logic [KEY_W-1:0] key_edge_q, key_edge_d;
  logic [CNT_W-1:0] cnt_q [KEY_W];
  logic [CNT_W-1:0] cnt_d [KEY_W];

  logic [KEY_W-1:0] key_pressed;
  logic [KEY_W-1:0] key_rise;
  logic [KEY_W-1:0] key_clr;

  assign key_pressed = ~sync2_q;

  // Software-visible register next-state: LEDS, HEX and TICK.
  always_comb begin
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    leds_d = leds_q;
    hex_d  = hex_q;
    tick_d = tick_q + 32'd1;
    if (wr_en && reg_idx == REG_LEDS) leds_d = wdata[LED_W-1:0];
    if (wr_en && reg_idx == REG_HEX)  hex_d  = wdata[HEX_W-1:0];
    // A loaded value keeps counting, so the first cycle after the write reads wdata+1.
    if (wr_en && reg_idx == REG_TICK) tick_d = wdata + 32'd1;
  end

  // Key path: two-flop synchroniser on the raw active-low buttons.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // Per-key debounce counter; level toggles after DEBOUNCE_CYC stable cycles.
  always_comb begin
    // NOTE: always_comb uses blocking '=' so later lines see the values computed above.
    key_level_d = key_level_q;
    for (int i = 0; i < KEY_W; i++) begin
      cnt_d[i] = '0;
      if (key_pressed[i] != key_level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          key_level_d[i] = ~key_level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Sticky press events: rising level sets, W1C clears, set beats clear.
  always_comb begin
    key_rise   = key_level_d & ~key_level_q;
    key_clr    = (wr_en && reg_idx == REG_KEY_EDGE) ? wdata[KEY_W-1:0] : '0;
    key_edge_d = (key_edge_q & ~key_clr) | key_rise;
  end

  // Main state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q      <= '0;
      hex_q       <= '0;
      tick_q      <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      key_level_q <= '0;
      key_edge_q  <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
      // explicitly; reset must discard any debounce progress in flight.
      for (int i = 0; i < KEY_W; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so all flops update together.
      leds_q      <= leds_d;
      hex_q       <= hex_d;
      tick_q      <= tick_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_level_q <= key_level_d;
      key_edge_q  <= key_edge_d;
      for (int i = 0; i < KEY_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef MMIO_IO_IRQ_EN
  logic [KEY_W-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;

  // Interrupt mask write and registered interrupt request.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && reg_idx == REG_IRQ_MASK) irq_mask_d = wdata[KEY_W-1:0];
    irq_d = |(key_edge_q & irq_mask_q);
  end

  // Interrupt state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; the single-cycle CPU consumes rdata in the same cycle.
  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (reg_idx)
        REG_LEDS:      rdata[LED_W-1:0] = leds_q;
        REG_HEX:       rdata[HEX_W-1:0] = hex_q;
        REG_KEY_LEVEL: rdata[KEY_W-1:0] = key_level_q;
        REG_KEY_EDGE:  rdata[KEY_W-1:0] = key_edge_q;
        REG_TICK:      rdata            = tick_q;
`ifdef MMIO_IO_IRQ_EN
        REG_IRQ_MASK:  rdata[KEY_W-1:0] = irq_mask_q;
`else
        REG_IRQ_MASK:  rdata            = '0;
`endif
        REG_RSVD6:     rdata            = '0;
        REG_RSVD7:     rdata            = '0;
        default:       rdata            = '0;
      endcase
    end
  end

  assign leds       = leds_q;
  assign hex_digits = hex_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed testbench for mmio_io_ctrl with DEBOUNCE_CYC=4.
// Expected values are queued before each observation and popped when compared.
module tb_mmio_io_ctrl;

  localparam int LED_W   = 10;
  localparam int NUM_HEX = 6;
  localparam int KEY_W   = 4;
  localparam int DEB     = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sel;
  logic                 we;
  logic [4:0]           addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic [KEY_W-1:0]     key_n;
  logic [LED_W-1:0]     leds;
  logic [4*NUM_HEX-1:0] hex_digits;
  logic                 irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  mmio_io_ctrl #(
    .LED_W(LED_W), .NUM_HEX(NUM_HEX), .KEY_W(KEY_W), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .key_n(key_n), .leds(leds), .hex_digits(hex_digits), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] e);
    sb_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t item;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0x%08h with no expected value queued", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic check_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] v;
    expect_val(tag, e);
    rd(a, v);
    check(v);
  endtask

  task automatic check_port(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check(obs);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    we  = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    key_n = '1;
    repeat (3) @(negedge clk);

    // Reset state: every offset reads zero, outputs low.
    for (int i = 0; i < 8; i++) check_rd($sformatf("reset_rd_%02h", i * 4), 5'(i * 4), 32'h0);
    check_port("reset_leds", 32'(leds), 32'h0);
    check_port("reset_hex", 32'(hex_digits), 32'h0);
    check_port("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // LED and HEX registers.
    wr(5'h00, 32'h0000_03FF);
    wr(5'h04, 32'h00AB_CDEF);
    check_port("leds_out", 32'(leds), 32'h3FF);
    check_port("hex_out", 32'(hex_digits), 32'hABCDEF);
    check_rd("leds_rd", 5'h00, 32'h3FF);
    check_rd("hex_rd", 5'h04, 32'hABCDEF);
    wr(5'h00, 32'hFFFF_F155);
    check_rd("leds_trunc_rd", 5'h00, 32'h155);
    wr(5'h07, 32'h0012_3456);
    check_rd("hex_lsb_ignored", 5'h04, 32'h123456);

    // Write with sel low must not land; unselected reads are zero.
    @(negedge clk);
    sel = 1'b0; we = 1'b1; addr = 5'h00; wdata = 32'h0;
    @(negedge clk);
    we = 1'b0;
    check_port("leds_nosel_write", 32'(leds), 32'h155);
    expect_val("rdata_unselected", 32'h0);
    sel = 1'b0; addr = 5'h00; #1;
    check(rdata);

    // Read-only and unmapped offsets ignore writes.
    wr(5'h08, 32'hF);
    check_rd("key_level_ro", 5'h08, 32'h0);
    wr(5'h18, 32'hFFFF_FFFF);
    check_rd("unmapped_18", 5'h18, 32'h0);
    check_rd("unmapped_1c", 5'h1C, 32'h0);

    // Clean press of key 2: visible exactly 2+DEB cycles after the edge.
    @(negedge clk);
    key_n[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_rd("press_lvl_early", 5'h08, 32'h0);
    check_rd("press_edge_early", 5'h0C, 32'h0);
    @(posedge clk);
    #1;
    check_rd("press_lvl_on_time", 5'h08, 32'h4);
    check_rd("press_edge_on_time", 5'h0C, 32'h4);
    repeat (14) @(posedge clk);
    #1;
    key_n[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_rd("release_lvl", 5'h08, 32'h0);
    check_rd("release_edge_kept", 5'h0C, 32'h4);

    // Short glitch on key 1 is filtered.
    @(negedge clk);
    key_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[1] = 1'b1;
    repeat (10) @(negedge clk);
    check_rd("glitch_lvl", 5'h08, 32'h0);
    check_rd("glitch_edge", 5'h0C, 32'h4);

    // W1C, then clear coinciding with a new rise: set wins.
    wr(5'h0C, 32'h4);
    check_rd("w1c_clear", 5'h0C, 32'h0);
    @(negedge clk);
    key_n[2] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 5'h0C; wdata = 32'h4;
    @(negedge clk);
    we = 1'b0; sel = 1'b0;
    check_rd("set_wins_lvl", 5'h08, 32'h4);
    check_rd("set_wins_edge", 5'h0C, 32'h4);
    wr(5'h0C, 32'h4);
    check_rd("w1c_clear2", 5'h0C, 32'h0);
    key_n[2] = 1'b1;
    repeat (8) @(negedge clk);
    check_rd("release2_lvl", 5'h08, 32'h0);

    // Tick load and wrap.
    wr(5'h10, 32'hFFFF_FFFE);
    check_rd("tick_0", 5'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    check_rd("tick_wrap", 5'h10, 32'h0000_0000);
    @(negedge clk);
    check_rd("tick_after_wrap", 5'h10, 32'h0000_0001);

`ifdef MMIO_IO_IRQ_EN
    // Interrupt: masked key 0 raises irq one cycle after its edge bit sets.
    wr(5'h14, 32'h1);
    check_rd("irq_mask_rd", 5'h14, 32'h1);
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_rd("irq_edge0_set", 5'h0C, 32'h1);
    check_port("irq_not_yet", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    check_port("irq_rise", 32'(irq), 32'h1);
    key_n[0] = 1'b1;
    repeat (8) @(negedge clk);
    check_port("irq_sticky", 32'(irq), 32'h1);
    wr(5'h0C, 32'h1);
    check_port("irq_hold_one_cycle", 32'(irq), 32'h1);
    @(posedge clk);
    #1;
    check_port("irq_fall", 32'(irq), 32'h0);
    // Unmasked key 3 leaves irq low; masking it later raises irq, unmasking drops it.
    @(negedge clk);
    key_n[3] = 1'b0;
    repeat (10) @(negedge clk);
    check_rd("irq_key3_edge", 5'h0C, 32'h8);
    check_port("irq_unmasked_low", 32'(irq), 32'h0);
    key_n[3] = 1'b1;
    wr(5'h14, 32'h8);
    check_port("irq_mask_delay", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    check_port("irq_mask_rise", 32'(irq), 32'h1);
    wr(5'h14, 32'h0);
    @(posedge clk);
    #1;
    check_port("irq_unmask_fall", 32'(irq), 32'h0);
    wr(5'h0C, 32'h8);
    repeat (8) @(negedge clk);
`else
    // Without the interrupt feature 0x14 is inert and irq stays low.
    wr(5'h14, 32'hF);
    check_rd("irq_mask_absent", 5'h14, 32'h0);
    @(negedge clk);
    key_n[3] = 1'b0;
    repeat (10) @(negedge clk);
    check_rd("key3_edge", 5'h0C, 32'h8);
    check_port("irq_tied_low", 32'(irq), 32'h0);
    key_n[3] = 1'b1;
    wr(5'h0C, 32'h8);
    repeat (8) @(negedge clk);
`endif

    // Reset mid-operation discards debounce progress.
    wr(5'h00, 32'h3FF);
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_port("midrst_leds", 32'(leds), 32'h0);
    check_rd("midrst_tick", 5'h10, 32'h0);
    check_rd("midrst_lvl", 5'h08, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_rd("midrst_lvl_early", 5'h08, 32'h0);
    @(posedge clk);
    #1;
    check_rd("midrst_lvl_on_time", 5'h08, 32'h1);
    check_rd("midrst_edge_on_time", 5'h0C, 32'h1);
    check_port("midrst_irq", 32'(irq), 32'h0);
    key_n[0] = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
